// File: rtl/prm_oblgc_chk_engine_pkg.sv
// -----------------------------------------------------------------------------
// prm_oblgc_pkg
// Shared types and sizing for the programmable obstacle-logic checker engine.
//   cube_t     : one sum-of-products term (care mask, literal polarity, edge id)
//   state_e    : engine FSM states
//   cube_match : term evaluation against an occupancy vector
// -----------------------------------------------------------------------------
package prm_oblgc_pkg;

  localparam int IN_W            = 15;   // occupancy bits, bit 0 = A .. bit 14 = O
  localparam int NUM_EDGES       = 8;    // edge channels / result mask width
  localparam int TERMS_MAX       = 256;  // cube table depth (power of two)
  localparam int CUBES_PER_CYCLE = 4;    // cubes evaluated per scan cycle

  localparam int ADDR_W = $clog2(TERMS_MAX);
  localparam int EDGE_W = $clog2(NUM_EDGES);
  localparam int CNT_W  = ADDR_W + 1;              // holds 0..TERMS_MAX
  localparam int LANE_W = $clog2(CUBES_PER_CYCLE); // bank select bits
  localparam int ROW_W  = ADDR_W - LANE_W;         // row within a bank
  localparam int ROWS   = TERMS_MAX / CUBES_PER_CYCLE;
  localparam int GRP_W  = ROW_W + 1;               // scan group counter

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TERMS_MAX);

  typedef struct packed {
    logic [IN_W-1:0]   care;    // 1 = variable appears in the cube
    logic [IN_W-1:0]   val;     // 1 = true literal, 0 = negated literal
    logic [EDGE_W-1:0] edge_id; // edge channel this cube ORs into
  } cube_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  // A cube matches when every cared-for bit equals its literal polarity.
  // care = 0 makes the cube a constant-1 term.
  function automatic logic cube_match(input logic [IN_W-1:0] q, input cube_t c);
    return ((q ^ c.val) & c.care) == '0;
  endfunction

endpackage

// File: rtl/prm_oblgc_chk_engine_if.sv
// -----------------------------------------------------------------------------
// prm_oblgc_chk_engine_if
// Query and result channels of the checker engine.
//   q_valid/q_ready/q_data : occupancy query in
//   r_valid/r_ready/r_mask : per-edge collision mask out
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. Once valid is raised, the source holds valid and its payload
// stable until that transfer; ready may change freely.
// -----------------------------------------------------------------------------
interface prm_oblgc_chk_engine_if;
  import prm_oblgc_pkg::*;

  logic                 q_valid;
  logic                 q_ready;
  logic [IN_W-1:0]      q_data;
  logic                 r_valid;
  logic                 r_ready;
  logic [NUM_EDGES-1:0] r_mask;

  modport master (
    output q_valid, q_data, r_ready,
    input  q_ready, r_valid, r_mask
  );

  modport slave (
    input  q_valid, q_data, r_ready,
    output q_ready, r_valid, r_mask
  );
endinterface

// File: rtl/prm_oblgc_chk_engine_cube_ram.sv
// -----------------------------------------------------------------------------
// prm_cube_ram
// Cube table: one write port, CUBES_PER_CYCLE-wide synchronous read. Entry i
// lives in bank (i mod CUBES_PER_CYCLE), row (i / CUBES_PER_CYCLE), so one row
// read returns a whole aligned group of cubes.
//   clk     : clock
//   we      : write strobe
//   wr_addr : table index to write
//   wr_data : cube to store
//   rd_row  : group index to read (data appears next cycle)
//   rd_data : registered group, lane b = entry rd_row*CUBES_PER_CYCLE + b
// Contents are not reset.
// -----------------------------------------------------------------------------
module prm_cube_ram
  import prm_oblgc_pkg::*;
(
  input  logic                              clk,
  input  logic                              we,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  cube_t                             wr_data,
  input  logic [ROW_W-1:0]                  rd_row,
  output cube_t [CUBES_PER_CYCLE-1:0]       rd_data
);

  for (genvar b = 0; b < CUBES_PER_CYCLE; b++) begin : g_bank
    cube_t mem [ROWS];
    cube_t rd_q;

    // Read-before-write: a read of the row being written returns old data.
    always_ff @(posedge clk) begin
      if (we && (wr_addr[LANE_W-1:0] == LANE_W'(b))) begin
        mem[wr_addr[ADDR_W-1:LANE_W]] <= wr_data;
      end
      rd_q <= mem[rd_row];
    end

    assign rd_data[b] = rd_q;
  end

endmodule

// File: rtl/prm_oblgc_chk_engine.sv
// -----------------------------------------------------------------------------
// prm_oblgc_chk_engine
// Programmable obstacle-logic checker. Scans a runtime-loaded cube table
// against each occupancy query and returns one collision bit per roadmap edge.
//   clk, rst_n              : clock, async active-low reset
//   cfg_we/addr/care/val/edge : cube table write (accepted only in IDLE)
//   cfg_cnt_we/cfg_cnt      : number of active cubes (saturates at TERMS_MAX)
//   cfg_err                 : one-cycle pulse on a rejected/saturated write
//   busy                    : high in SCAN or DONE
//   dbg_state               : current FSM state
//   bus (slave)             : query in, result mask out
// Latency from query accept to r_valid: ceil(term_cnt/CUBES_PER_CYCLE) + 1.
// -----------------------------------------------------------------------------
module prm_oblgc_chk_engine
  import prm_oblgc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [IN_W-1:0]       cfg_care,
  input  logic [IN_W-1:0]       cfg_val,
  input  logic [EDGE_W-1:0]     cfg_edge,
  input  logic                  cfg_cnt_we,
  input  logic [CNT_W-1:0]      cfg_cnt,
  output logic                  cfg_err,
  output logic                  busy,
  output state_e                dbg_state,
  prm_oblgc_chk_engine_if.slave bus
);

  state_e                          state;
  logic   [CNT_W-1:0]              term_cnt;
  logic   [CNT_W-1:0]              scan_cnt;   // term count frozen at accept
  logic   [GRP_W-1:0]              grp;        // group currently on rd_data
  logic   [IN_W-1:0]               q_lat;
  logic   [NUM_EDGES-1:0]          acc;
  logic   [NUM_EDGES-1:0]          hits;
  logic   [NUM_EDGES-1:0]          r_mask_q;
  logic                            r_valid_q;
  logic                            q_ready_q;
  logic                            busy_q;
  logic                            cfg_err_q;
  logic   [CNT_W-1:0]              ptr;
  logic                            scan_last;
  logic                            ram_we;
  cube_t                           wr_cube;
  logic   [ROW_W-1:0]              rd_row;
  cube_t  [CUBES_PER_CYCLE-1:0]    rd_data;

  assign ram_we  = cfg_we && (state == IDLE);
  assign wr_cube = '{care: cfg_care, val: cfg_val, edge_id: cfg_edge};

  // Reads run one group ahead: group 0 is fetched in the accept cycle, and
  // while group g is evaluated in SCAN, group g+1 is fetched. This hides the
  // one-cycle RAM latency.
  always_comb begin
    rd_row = '0;
    if (state == SCAN) begin
      rd_row = grp[ROW_W-1:0] + ROW_W'(1);
    end
  end

  prm_cube_ram u_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (cfg_addr),
    .wr_data (wr_cube),
    .rd_row  (rd_row),
    .rd_data (rd_data)
  );

  assign ptr       = {grp, LANE_W'(0)};
  assign scan_last = (ptr + CNT_W'(CUBES_PER_CYCLE)) >= scan_cnt;

  // Lanes past the active count are masked so stale table contents in a
  // partially used last group never contribute.
  always_comb begin
    hits = '0;
    for (int j = 0; j < CUBES_PER_CYCLE; j++) begin
      if (((ptr + CNT_W'(j)) < scan_cnt) && cube_match(q_lat, rd_data[j])) begin
        hits[rd_data[j].edge_id] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      term_cnt  <= '0;
      scan_cnt  <= '0;
      grp       <= '0;
      q_lat     <= '0;
      acc       <= '0;
      r_mask_q  <= '0;
      r_valid_q <= 1'b0;
      q_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;

      if (state != IDLE) begin
        if (cfg_we || cfg_cnt_we) begin
          cfg_err_q <= 1'b1;
        end
      end else if (cfg_cnt_we) begin
        if (cfg_cnt > CNT_MAX) begin
          term_cnt  <= CNT_MAX;
          cfg_err_q <= 1'b1;
        end else begin
          term_cnt <= cfg_cnt;
        end
      end

      case (state)
        IDLE: begin
          q_ready_q <= 1'b1;
          if (bus.q_valid && q_ready_q) begin
            q_lat     <= bus.q_data;
            acc       <= '0;
            grp       <= '0;
            scan_cnt  <= term_cnt;
            q_ready_q <= 1'b0;
            busy_q    <= 1'b1;
            if (term_cnt == '0) begin
              state     <= DONE;
              r_valid_q <= 1'b1;
              r_mask_q  <= '0;
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          acc <= acc | hits;
          if (scan_last) begin
            state     <= DONE;
            r_valid_q <= 1'b1;
            r_mask_q  <= acc | hits;
          end else begin
            grp <= grp + GRP_W'(1);
          end
        end
        DONE: begin
          if (bus.r_ready) begin
            state     <= IDLE;
            r_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            q_ready_q <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          r_valid_q <= 1'b0;
          busy_q    <= 1'b0;
          q_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q_ready = q_ready_q;
  assign bus.r_valid = r_valid_q;
  assign bus.r_mask  = r_mask_q;
  assign cfg_err     = cfg_err_q;
  assign busy        = busy_q;
  assign dbg_state   = state;

endmodule
